// File: rtl/debounce_sync.sv
// debounce_sync
//   Turns a raw asynchronous single-bit input (button/switch) into a clean
//   clock-synchronous level plus one-cycle pulses on accepted edges.
//   din -> SYNC_STAGES flop synchronizer -> s -> 4-state debounce FSM.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   din    in   raw asynchronous input (feeds the synchronizer only)
//   q      out  debounced level, registered
//   rise   out  one-cycle pulse on accepted 0->1 transition, registered
//   fall   out  one-cycle pulse on accepted 1->0 transition, registered
//   glitch out  one-cycle pulse when a pending transition is aborted, registered
//
// Parameters
//   SYNC_STAGES     synchronizer depth, 2..4
//   DEBOUNCE_CYCLES stable synchronized cycles needed, 1..2^CNT_W
//   CNT_W           debounce counter width
//
// state     | meaning
// ----------+-------------------------------------------------------
// STABLE_LO | q=0 accepted, waiting for s to go high
// CHECK_HI  | q=0, s went high, counting stable-high cycles
// STABLE_HI | q=1 accepted, waiting for s to go low
// CHECK_LO  | q=1, s went low, counting stable-low cycles

module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic glitch
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  // Terminal count: the check that sees the (DEBOUNCE_CYCLES)th stable
  // sample after entry completes, so cnt never passes this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   q_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   glitch_q;

  // Synchronizer chain; din is touched nowhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      q_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (s) begin
            state_q <= CHECK_HI;
            cnt_q   <= '0;
          end
        end
        CHECK_HI: begin
          if (!s) begin
            state_q  <= STABLE_LO;
            glitch_q <= 1'b1;
            cnt_q    <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            q_q     <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state_q <= CHECK_LO;
            cnt_q   <= '0;
          end
        end
        CHECK_LO: begin
          if (s) begin
            state_q  <= STABLE_HI;
            glitch_q <= 1'b1;
            cnt_q    <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LO;
            q_q     <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
          q_q     <= 1'b0;
        end
      endcase
    end
  end

  assign q      = q_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign glitch = glitch_q;

endmodule
